// File: rtl/pc_gen_unit.sv
// Program-counter generator for the fetch stage: boot/run/halt sequencing,
// prioritised trap/redirect handling, stall hold and a saturating redirect counter.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             pc_valid,
    output logic             misaligned_err,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state_reg;
    logic [XLEN-1:0]  pc_reg;
    logic             valid_reg;
    logic             mis_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             target_aligned;

    // With no alignment constraint every redirect target is acceptable.
    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign target_aligned = (redirect_target[ALIGN_BITS-1:0] == '0);
        end else begin : g_align_none
            assign target_aligned = 1'b1;
        end
    endgenerate

    assign pc_plus_inc = pc_reg + XLEN'(INC);
    assign cnt_next    = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_VECTOR;
            valid_reg <= 1'b0;
            mis_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            mis_reg <= 1'b0;
            case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
                    valid_reg <= 1'b1;
                end
                RUN: begin
                    if (trap) begin
                        pc_reg  <= TRAP_VECTOR;
                        cnt_reg <= cnt_next;
                    end else if (redirect_valid && target_aligned) begin
                        pc_reg  <= redirect_target;
                        cnt_reg <= cnt_next;
                    end else if (redirect_valid) begin
                        // Misaligned target: divert to the trap handler and flag it.
                        pc_reg  <= TRAP_VECTOR;
                        mis_reg <= 1'b1;
                        cnt_reg <= cnt_next;
                    end else if (halt_req) begin
                        state_reg <= HALT;
                        valid_reg <= 1'b0;
                    end else if (!stall) begin
                        pc_reg <= pc_plus_inc;
                    end
                end
                HALT: begin
                    if (trap) begin
                        state_reg <= RUN;
                        valid_reg <= 1'b1;
                        pc_reg    <= TRAP_VECTOR;
                        cnt_reg   <= cnt_next;
                    end else if (resume) begin
                        state_reg <= RUN;
                        valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out         = pc_reg;
    assign pc_valid       = valid_reg;
    assign misaligned_err = mis_reg;
    assign redirect_count = cnt_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit; a second instance with a 2-bit counter checks saturation.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;

    logic [31:0] pc_out, pc_plus_inc;
    logic        pc_valid, misaligned_err;
    logic [15:0] redirect_count;

    logic [31:0] s_pc_out, s_pc_plus_inc;
    logic        s_pc_valid, s_misaligned_err;
    logic [1:0]  s_redirect_count;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    pc_gen_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap(trap), .halt_req(halt_req),
        .resume(resume), .pc_out(pc_out), .pc_plus_inc(pc_plus_inc),
        .pc_valid(pc_valid), .misaligned_err(misaligned_err),
        .redirect_count(redirect_count)
    );

    pc_gen_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap(trap), .halt_req(halt_req),
        .resume(resume), .pc_out(s_pc_out), .pc_plus_inc(s_pc_plus_inc),
        .pc_valid(s_pc_valid), .misaligned_err(s_misaligned_err),
        .redirect_count(s_redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        logic [31:0] sat_exp;
        sat_exp = (e.cnt > 16'd3) ? 32'd3 : {16'd0, e.cnt};
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus_inc", pc_plus_inc, e.pc + 32'd4);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
        chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, e.mis});
        chk("redirect_count", {16'd0, redirect_count}, {16'd0, e.cnt});
        chk("sat_count", {30'd0, s_redirect_count}, sat_exp);
    endtask

    // One clock transaction: drive inputs, queue expectation, compare after the edge.
    task automatic step(input logic st, input logic rv, input logic [31:0] tgt,
                        input logic tr, input logic hr, input logic rs,
                        input logic [31:0] e_pc, input logic e_valid,
                        input logic e_mis, input logic [15:0] e_cnt);
        exp_t e;
        stall = st; redirect_valid = rv; redirect_target = tgt;
        trap = tr; halt_req = hr; resume = rs;
        e.pc = e_pc; e.valid = e_valid; e.mis = e_mis; e.cnt = e_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = sb_q.pop_front();
        check_outputs(e);
        $display("step %0d: pc=%h valid=%0b mis=%0b cnt=%0d sat=%0d",
                 step_no, pc_out, pc_valid, misaligned_err, redirect_count, s_redirect_count);
    endtask

    task automatic reset_check();
        exp_t e;
        e.pc = 32'h0; e.valid = 1'b0; e.mis = 1'b0; e.cnt = 16'd0;
        check_outputs(e);
        $display("reset check: pc=%h valid=%0b mis=%0b cnt=%0d",
                 pc_out, pc_valid, misaligned_err, redirect_count);
    endtask

    initial begin
        // Held in reset across two edges.
        repeat (2) @(posedge clk);
        #1;
        reset_check();
        rst = 1'b1;

        // Boot, then sequential fetch.
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_0000, 1, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_0004, 1, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_0008, 1, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_000C, 1, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_0010, 1, 0, 0);

        // Stall hold, then redirect overriding stall.
        step(1, 0, 32'h0,   0, 0, 0, 32'h0000_0010, 1, 0, 0);
        step(1, 0, 32'h0,   0, 0, 0, 32'h0000_0010, 1, 0, 0);
        step(1, 1, 32'h200, 0, 0, 0, 32'h0000_0200, 1, 0, 1);
        step(0, 0, 32'h0,   0, 0, 0, 32'h0000_0204, 1, 0, 1);

        // Misaligned redirect: trap vector and a single-cycle error pulse.
        step(0, 1, 32'h202, 0, 0, 0, 32'h0000_0100, 1, 1, 2);
        step(0, 0, 32'h0,   0, 0, 0, 32'h0000_0104, 1, 0, 2);

        // Trap beats redirect, counted once.
        step(0, 1, 32'h400, 1, 0, 0, 32'h0000_0100, 1, 0, 3);

        // Halt (with simultaneous resume) at 0x20, inputs ignored in HALT.
        step(0, 1, 32'h1C,  0, 0, 0, 32'h0000_001C, 1, 0, 4);
        step(0, 0, 32'h0,   0, 0, 0, 32'h0000_0020, 1, 0, 4);
        step(0, 0, 32'h0,   0, 1, 1, 32'h0000_0020, 0, 0, 4);
        step(0, 1, 32'h300, 0, 0, 0, 32'h0000_0020, 0, 0, 4);
        step(1, 1, 32'h302, 0, 1, 0, 32'h0000_0020, 0, 0, 4);
        step(0, 1, 32'h500, 0, 0, 0, 32'h0000_0020, 0, 0, 4);
        step(0, 0, 32'h0,   0, 0, 1, 32'h0000_0020, 1, 0, 4);
        step(0, 0, 32'h0,   0, 0, 0, 32'h0000_0024, 1, 0, 4);

        // Redirect beats halt; later halt, then trap leaves HALT.
        step(0, 1, 32'h40,  0, 1, 0, 32'h0000_0040, 1, 0, 5);
        step(0, 0, 32'h0,   0, 1, 0, 32'h0000_0040, 0, 0, 5);
        step(0, 0, 32'h0,   1, 0, 0, 32'h0000_0100, 1, 0, 6);
        step(0, 0, 32'h0,   0, 0, 0, 32'h0000_0104, 1, 0, 6);
        step(0, 0, 32'h0,   0, 0, 1, 32'h0000_0108, 1, 0, 6);

        // Wrap-around at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 7);
        step(0, 0, 32'h0,         0, 0, 0, 32'h0000_0000, 1, 0, 7);
        step(0, 0, 32'h0,         0, 0, 0, 32'h0000_0004, 1, 0, 7);

        // Misaligned pulse, then asynchronous reset before the next edge.
        step(0, 1, 32'h801, 0, 0, 0, 32'h0000_0100, 1, 1, 8);
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        #2;
        rst = 1'b0;
        #1;
        reset_check();
        @(posedge clk);
        #1;
        reset_check();
        rst = 1'b1;
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_0000, 1, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0000_0004, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
